// File: rtl/memory_arbiter.sv
// Shares the CPU's single memory port between instruction fetch (IF) and data load/store (DS).
// Define ARB_ROUND_ROBIN_EN for alternating grants under contention; default is DS-over-IF.
module memory_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,

    input  logic                    ds_req_valid,
    output logic                    ds_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ds_addr,
    input  logic                    ds_write,
    input  logic [DATA_WIDTH-1:0]   ds_wdata,
    input  logic [DATA_WIDTH/8-1:0] ds_wstrb,
    output logic                    ds_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ds_rsp_data,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
    typedef enum logic {OwnerIf = 1'b0, OwnerDs = 1'b1} owner_e;

    state_e                  state_q, state_d;
    owner_e                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;

    logic grant_if;
    logic grant_ds;
    logic rsp_fire;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers who won the last grant; resets to IF so the first contended grant goes to DS.
    owner_e last_grant_q, last_grant_d;

    always_comb begin
        grant_ds = ds_req_valid;
        grant_if = if_req_valid;
        if (if_req_valid && ds_req_valid) begin
            grant_ds = (last_grant_q == OwnerIf);
            grant_if = (last_grant_q == OwnerDs);
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == StIdle) begin
            if (grant_ds) begin
                last_grant_d = OwnerDs;
            end else if (grant_if) begin
                last_grant_d = OwnerIf;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= OwnerIf;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign grant_ds = ds_req_valid;
    assign grant_if = if_req_valid && !ds_req_valid;
`endif

    // A response completes in WAIT, or in ISSUE when the request and response share a cycle.
    assign rsp_fire = !reset && mem_rsp_valid &&
                      ((state_q == StWait) || ((state_q == StIssue) && mem_req_ready));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        unique case (state_q)
            StIdle: begin
                if (grant_ds) begin
                    owner_d = OwnerDs;
                    addr_d  = ds_addr;
                    write_d = ds_write;
                    wdata_d = ds_wdata;
                    wstrb_d = ds_wstrb;
                    state_d = StIssue;
                end else if (grant_if) begin
                    owner_d = OwnerIf;
                    addr_d  = if_addr;
                    write_d = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (mem_req_ready) begin
                    state_d = mem_rsp_valid ? StIdle : StWait;
                end
            end
            StWait: begin
                if (mem_rsp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= OwnerIf;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign if_req_ready  = !reset && (state_q == StIdle) && grant_if;
    assign ds_req_ready  = !reset && (state_q == StIdle) && grant_ds;

    assign if_rsp_valid  = rsp_fire && (owner_q == OwnerIf);
    assign ds_rsp_valid  = rsp_fire && (owner_q == OwnerDs);
    assign if_rsp_data   = mem_rsp_data;
    assign ds_rsp_data   = mem_rsp_data;

    assign mem_req_valid = (state_q == StIssue);
    assign mem_addr      = addr_q;
    assign mem_write     = write_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;

endmodule
